// File: rtl/fc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq_pkg
// Purpose  : Shared types and constants for the fc sequencer slice.
// Revision : 1.0 - initial release
// ============================================================================
package fc_seq_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANES  = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Lane k of a packed feature group, lane 0 in the LSBs.
  function automatic logic [DEF_DATA_W-1:0] lane_slice(
    input logic [DEF_LANES*DEF_DATA_W-1:0] bus,
    input int unsigned                     k
  );
    lane_slice = bus[k*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq_if
// Purpose  : Sequencer <-> fc datapath link (weights, feature beats, result).
// Revision : 1.0 - initial release
// ============================================================================
interface fc_seq_if
  import fc_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
);
  logic                       fc_weight;
  logic                       fc_weight_en;
  logic                       fc_ivalid;
  logic [LANES*DATA_W-1:0]    fc_din;
  logic                       fc_ovalid;
  logic signed [DATA_W-1:0]   fc_dout;

  modport master (
    output fc_weight, fc_weight_en, fc_ivalid, fc_din,
    input  fc_ovalid, fc_dout
  );

  modport slave (
    input  fc_weight, fc_weight_en, fc_ivalid, fc_din,
    output fc_ovalid, fc_dout
  );
endinterface
`default_nettype wire

// File: rtl/fc_seq_wload.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq_wload
// Purpose  : Serial weight loader; reads N_WEIGHTS bits and replays them to fc.
// Revision : 1.0 - initial release
// ============================================================================
module fc_seq_wload #(
  parameter int N_WEIGHTS = 192
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         finish,
  output logic                         wmem_rd,
  output logic [$clog2(N_WEIGHTS)-1:0] wmem_addr,
  input  logic                         wmem_data,
  output logic                         weight,
  output logic                         weight_en
);
  localparam int AW = $clog2(N_WEIGHTS);

  logic          rd_q,   rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          en_q,   en_d;
  logic          fin_q,  fin_d;

  always_comb begin
    rd_d   = rd_q;
    addr_d = addr_q;
    if (start) begin
      rd_d   = 1'b1;
      addr_d = '0;
    end else if (rd_q) begin
      if (addr_q == AW'(N_WEIGHTS-1)) begin
        rd_d   = 1'b0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
    // Memory returns the bit one cycle after the read, so the enable trails it.
    en_d  = rd_q;
    fin_d = en_q & ~rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= 1'b0;
      addr_q <= '0;
      en_q   <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      addr_q <= addr_d;
      en_q   <= en_d;
      fin_q  <= fin_d;
    end
  end

  assign wmem_rd   = rd_q;
  assign wmem_addr = addr_q;
  assign weight_en = en_q;
  assign weight    = en_q & wmem_data;
  assign finish    = fin_q;

endmodule
`default_nettype wire

// File: rtl/fc_seq.sv
`default_nettype none
// ============================================================================
// Module   : fc_seq
// Purpose  : Sequencer for the BNN fc datapath: weight load, feature feed,
//            result capture. Optional drain watchdog: FC_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fc_seq
  import fc_seq_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LANES     = DEF_LANES,
  parameter int N_WEIGHTS = 192,
  parameter int N_GROUPS  = 32,
  parameter int GAP       = 1,
  parameter int N_OUT     = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reload_w,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         wmem_rd,
  output logic [$clog2(N_WEIGHTS)-1:0] wmem_addr,
  input  logic                         wmem_data,
  output logic                         fmem_rd,
  output logic [$clog2(N_GROUPS)-1:0]  fmem_addr,
  input  logic [LANES*DATA_W-1:0]      fmem_data,
  fc_seq_if.master                     fc,
  output logic                         res_valid,
  output logic [$clog2(N_OUT):0]       res_idx,
  output logic signed [DATA_W-1:0]     res_data
);
  localparam int GW = $clog2(N_GROUPS);
  localparam int PW = $clog2(GAP+1);
  localparam int CW = $clog2(N_OUT)+1;
  localparam int TW = $clog2(TIMEOUT+1);

`ifdef FC_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic [GW-1:0]           grp_q,   grp_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [CW-1:0]           ovcnt_q, ovcnt_d;
  logic [TW-1:0]           drain_q, drain_d;
  logic                    ivalid_q, ivalid_d;
  logic [LANES*DATA_W-1:0] din_q,   din_d;
  logic                    rv_q,    rv_d;
  logic [CW-1:0]           ridx_q,  ridx_d;
  logic signed [DATA_W-1:0] rdat_q, rdat_d;

  logic wl_start, wl_finish, wl_weight, wl_weight_en;
  logic accept, feed_last, timeout_hit, busy_w, ov_accept, reached;

  assign accept      = (state_q == IDLE) && start;
  assign wl_start    = accept && reload_w;
  assign feed_last   = (phase_q == PW'(GAP)) && (grp_q == GW'(N_GROUPS-1));
  assign reached     = (ovcnt_q == CW'(N_OUT));
  assign timeout_hit = TIMEOUT_ON && (drain_q == TW'(TIMEOUT-1));
  assign busy_w      = (state_q == WLOAD) || (state_q == FEED) || (state_q == DRAIN);
  assign ov_accept   = fc.fc_ovalid && busy_w && (ovcnt_q < CW'(N_OUT));

  fc_seq_wload #(
    .N_WEIGHTS (N_WEIGHTS)
  ) u_wload (
    .clk       (clk),
    .rst       (rst),
    .start     (wl_start),
    .finish    (wl_finish),
    .wmem_rd   (wmem_rd),
    .wmem_addr (wmem_addr),
    .wmem_data (wmem_data),
    .weight    (wl_weight),
    .weight_en (wl_weight_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grp_q    <= '0;
      phase_q  <= '0;
      ovcnt_q  <= '0;
      drain_q  <= '0;
      ivalid_q <= 1'b0;
      din_q    <= '0;
      rv_q     <= 1'b0;
      ridx_q   <= '0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      phase_q  <= phase_d;
      ovcnt_q  <= ovcnt_d;
      drain_q  <= drain_d;
      ivalid_q <= ivalid_d;
      din_q    <= din_d;
      rv_q     <= rv_d;
      ridx_q   <= ridx_d;
      rdat_q   <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)       state_d = reload_w ? WLOAD : FEED;
      WLOAD:   if (wl_finish)   state_d = FEED;
      FEED:    if (feed_last)   state_d = DRAIN;
      DRAIN:   if (reached || timeout_hit) state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    fmem_rd = 1'b0;
    case (state_q)
      WLOAD, DRAIN: busy = 1'b1;
      FEED: begin
        busy    = 1'b1;
        fmem_rd = (phase_q == '0);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath counters and result capture.
  always_comb begin
    grp_d   = '0;
    phase_d = '0;
    if (state_q == FEED) begin
      if (phase_q == PW'(GAP)) begin
        grp_d = grp_q + 1'b1;
      end else begin
        grp_d   = grp_q;
        phase_d = phase_q + 1'b1;
      end
    end
    drain_d = (state_q == DRAIN) ? drain_q + 1'b1 : '0;

    ovcnt_d = ovcnt_q;
    if (accept)         ovcnt_d = '0;
    else if (ov_accept) ovcnt_d = ovcnt_q + 1'b1;

    ivalid_d = fmem_rd;
    din_d    = ivalid_q ? fmem_data : din_q;
    rv_d     = ov_accept;
    ridx_d   = ov_accept ? ovcnt_q : ridx_q;
    rdat_d   = ov_accept ? fc.fc_dout : rdat_q;
  end

`ifdef FC_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept)
      err_d = 1'b0;
    else if ((state_q == DRAIN) && timeout_hit && !reached)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign fmem_addr       = grp_q;
  assign fc.fc_weight    = wl_weight;
  assign fc.fc_weight_en = wl_weight_en;
  assign fc.fc_ivalid    = ivalid_q;
  // Live memory data on the beat cycle, held copy between beats.
  assign fc.fc_din       = ivalid_q ? fmem_data : din_q;
  assign res_valid       = rv_q;
  assign res_idx         = ridx_q;
  assign res_data        = rdat_q;

endmodule
`default_nettype wire
